button_conditioner: RTL and testbench
=====================================

# button_conditioner

Conditions the two active-low push-button inputs of the board before they reach the Nios system's button PIO (`button_pio_external_connection_export[1:0]`). Each button is synchronised into the system clock domain and debounced by a per-button state machine. The block then drives a clean active-high pressed level into the PIO. It also generates one-cycle press, release and long-press event pulses for fabric logic such as systolic-array start/abort control.

## Interface
- `NUM_BUTTONS`, 2: number of independent button channels.
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles required to accept a level change (10 ms at 50 MHz); minimum 2.
- `LONG_PRESS_CYCLES`, 50000000: cycles a debounced press must persist before a long-press event fires (1 s at 50 MHz); must exceed `DEBOUNCE_CYCLES`.

- `clk`  in  1  system reference clock; same clock as `clocks_ref_clk_clk`.
- `reset`  in  1  synchronous, active-high reset.
- `button_n_raw`  in  NUM_BUTTONS  raw board keys, active-low, asynchronous to `clk`.
- `button_level`  out  NUM_BUTTONS  debounced pressed level, active-high; connects to `button_pio_external_connection_export`.
- `press_pulse`  out  NUM_BUTTONS  one-cycle pulse on an accepted release→press transition.
- `release_pulse`  out  NUM_BUTTONS  one-cycle pulse on an accepted press→release transition.
- `long_press_pulse`  out  NUM_BUTTONS  one-cycle pulse, at most once per press, when a hold reaches `LONG_PRESS_CYCLES`.

## Operation
- Synchroniser: each `button_n_raw` bit passes through two flops, `sync1` then `sync2`. Both reset to 1 (released). `pressed_s = ~sync2`.
- Each channel has its own FSM, debounce counter (`$clog2(DEBOUNCE_CYCLES)` bits) and hold counter (`$clog2(LONG_PRESS_CYCLES+1)` bits). Channels are fully independent.
- FSM states:
  - RELEASED: `button_level`=0. If `pressed_s`=1, go to PRESS_PEND with debounce counter = 1.
  - PRESS_PEND: if `pressed_s`=0, return to RELEASED and clear the counter. On the cycle the counter reaches `DEBOUNCE_CYCLES` with `pressed_s` still 1, go to PRESSED, set `button_level`=1, pulse `press_pulse`, and set the hold counter to 0. Otherwise increment the counter.
  - PRESSED: `button_level`=1. The hold counter increments each cycle and saturates at `LONG_PRESS_CYCLES`. On the cycle it becomes equal to `LONG_PRESS_CYCLES`, pulse `long_press_pulse`; it never pulses again this press. If `pressed_s`=0, go to RELEASE_PEND with debounce counter = 1. The hold counter keeps its value.
  - RELEASE_PEND: `button_level` stays 1 and the hold counter is frozen. If `pressed_s`=1, return to PRESSED and clear the debounce counter. On the cycle the counter reaches `DEBOUNCE_CYCLES` with `pressed_s` still 0, go to RELEASED, set `button_level`=0 and pulse `release_pulse`. Otherwise increment the counter.
- A bounce during RELEASE_PEND that returns to PRESSED does not re-arm the long press; that happens only via RELEASED.
- At most one of `press_pulse`, `release_pulse` and `long_press_pulse` is high per channel per cycle.

## Timing
- All outputs are registered. Reset values: `button_level`=0, all pulses 0, FSMs in RELEASED, counters 0, sync flops 1.
- Latency, raw edge to `button_level` change (raw held stable): 2 synchroniser cycles + `DEBOUNCE_CYCLES` cycles.
  - `press_pulse` / `release_pulse` are high in the same cycle `button_level` first shows the new value.
- `long_press_pulse` is asserted `LONG_PRESS_CYCLES` cycles after `press_pulse`.
- Any glitch shorter than `DEBOUNCE_CYCLES` cycles after synchronisation produces no output change and no pulse.
- Reset mid-operation:
  - Asserting `reset` in any state forces the reset values on the next edge and suppresses any pulse due that cycle.
  - A button held through reset is re-debounced from RELEASED after `reset` deasserts, producing a fresh `press_pulse`.
- Both buttons changing in the same cycle are handled independently, so both pulses may assert together.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `LONG_PRESS_CYCLES`=16.

- **Clean press:** reset, then drive `button_n_raw[0]`=0 held → `button_level[0]` rises and `press_pulse[0]` is high for exactly 1 cycle, 6 cycles after the raw edge; channel 1 stays 0.
- **Bounce rejection:** toggle `button_n_raw[1]` low for 3 cycles, high for 2, repeated 5 times → `button_level[1]` stays 0 and no pulses. Then hold low → press accepted 6 cycles after the final low edge.
- **Long press:** hold button 0 → `long_press_pulse[0]` fires once, 16 cycles after `press_pulse[0]`. Hold 40 more cycles → no further pulse. Release → `release_pulse[0]` 6 cycles after the raw edge.
- **Release bounce:** while pressed, raise raw for 3 cycles then low again → `button_level` stays 1, no `release_pulse`, no second `long_press_pulse`.
- **Simultaneous:** press both buttons on the same cycle → both `press_pulse` bits high in the same cycle.
- **Reset mid-press:** assert `reset` for 1 cycle while in PRESSED with raw still low → all outputs 0 next cycle. `press_pulse` re-fires 6 cycles after `reset` deasserts.

Source files
------------

// File: rtl/button_conditioner.sv
// button_conditioner
// Two-flop synchroniser plus a per-channel debounce FSM for active-low board
// keys. It drives a clean active-high pressed level, and one-cycle press,
// release and long-press event pulses for fabric control logic.
//
// Handshake note: this block has no valid/ready interfaces. Every output is a
// plain registered level or a one-cycle pulse, qualified by nothing but clk.
module button_conditioner #(
  parameter int NUM_BUTTONS       = 2,
  parameter int DEBOUNCE_CYCLES   = 500000,
  parameter int LONG_PRESS_CYCLES = 50000000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_BUTTONS-1:0]   button_n_raw,
  output logic [NUM_BUTTONS-1:0]   button_level,
  output logic [NUM_BUTTONS-1:0]   press_pulse,
  output logic [NUM_BUTTONS-1:0]   release_pulse,
  output logic [NUM_BUTTONS-1:0]   long_press_pulse,
  output logic [2*NUM_BUTTONS-1:0] o_dbg_state
);

  // Debounce counter only needs to hold 1..DEBOUNCE_CYCLES-1, because the
  // transition fires on the cycle the count would reach DEBOUNCE_CYCLES.
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  // Hold counter saturates at LONG_PRESS_CYCLES, so it must represent it.
  localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);

  localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DB_ONE      = DW'(1);
  localparam logic [HW-1:0] HOLD_MAX    = HW'(LONG_PRESS_CYCLES);
  localparam logic [HW-1:0] HOLD_BEFORE = HW'(LONG_PRESS_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RELEASED     = 2'd0,
    S_PRESS_PEND   = 2'd1,
    S_PRESSED      = 2'd2,
    S_RELEASE_PEND = 2'd3
  } state_t;

  logic [NUM_BUTTONS-1:0] r_sync1;
  logic [NUM_BUTTONS-1:0] r_sync2;
  logic [NUM_BUTTONS-1:0] w_pressed_s;

  // Two-flop synchroniser; both stages reset to the released (high) level.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= button_n_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_pressed_s = ~r_sync2;

  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_ch
    state_t        r_state;
    logic [DW-1:0] r_db_cnt;
    logic [HW-1:0] r_hold_cnt;
    logic          r_level;
    logic          r_press;
    logic          r_release;
    logic          r_long;

    // Per-channel debounce FSM with registered level and event pulses.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_state    <= S_RELEASED;
        r_db_cnt   <= '0;
        r_hold_cnt <= '0;
        r_level    <= 1'b0;
        r_press    <= 1'b0;
        r_release  <= 1'b0;
        r_long     <= 1'b0;
      end else begin
        // Pulses default low; a case arm below raises at most one of them.
        r_press   <= 1'b0;
        r_release <= 1'b0;
        r_long    <= 1'b0;
        case (r_state)
          S_RELEASED: begin
            r_level <= 1'b0;
            if (w_pressed_s[g]) begin
              r_state  <= S_PRESS_PEND;
              r_db_cnt <= DB_ONE;
            end
          end

          S_PRESS_PEND: begin
            if (!w_pressed_s[g]) begin
              // Glitch ended before it was stable long enough.
              r_state  <= S_RELEASED;
              r_db_cnt <= '0;
            end else if (r_db_cnt == DB_LAST) begin
              r_state    <= S_PRESSED;
              r_db_cnt   <= '0;
              r_level    <= 1'b1;
              r_press    <= 1'b1;
              // Long-press timing is armed only on a fresh accepted press.
              r_hold_cnt <= '0;
            end else begin
              r_db_cnt <= r_db_cnt + DB_ONE;
            end
          end

          S_PRESSED: begin
            r_level <= 1'b1;
            if (!w_pressed_s[g]) begin
              // Hold counter is left untouched so a release bounce cannot
              // re-arm or advance the long press.
              r_state  <= S_RELEASE_PEND;
              r_db_cnt <= DB_ONE;
            end else if (r_hold_cnt != HOLD_MAX) begin
              r_hold_cnt <= r_hold_cnt + HW'(1);
              if (r_hold_cnt == HOLD_BEFORE) begin
                r_long <= 1'b1;
              end
            end
          end

          S_RELEASE_PEND: begin
            r_level <= 1'b1;
            if (w_pressed_s[g]) begin
              r_state  <= S_PRESSED;
              r_db_cnt <= '0;
            end else if (r_db_cnt == DB_LAST) begin
              r_state   <= S_RELEASED;
              r_db_cnt  <= '0;
              r_level   <= 1'b0;
              r_release <= 1'b1;
            end else begin
              r_db_cnt <= r_db_cnt + DB_ONE;
            end
          end

          default: begin
            r_state  <= S_RELEASED;
            r_db_cnt <= '0;
            r_level  <= 1'b0;
          end
        endcase
      end
    end

    assign button_level[g]       = r_level;
    assign press_pulse[g]        = r_press;
    assign release_pulse[g]      = r_release;
    assign long_press_pulse[g]   = r_long;
    assign o_dbg_state[2*g +: 2] = r_state;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4 and
// LONG_PRESS_CYCLES=16: a per-cycle vector table plus hand-written
// sequences for bounce, long press, release bounce and reset mid-press.
module tb_button_conditioner;

  localparam int NB = 2;
  localparam int DB = 4;
  localparam int LP = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NB-1:0] button_n_raw = 2'b11;
  logic [NB-1:0] button_level;
  logic [NB-1:0] press_pulse;
  logic [NB-1:0] release_pulse;
  logic [NB-1:0] long_press_pulse;
  logic [2*NB-1:0] dbg_state;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0] raw;
    logic       rst;
    logic [1:0] lvl;
    logic [1:0] pr;
    logic [1:0] rl;
    logic [1:0] lg;
  } vec_t;

  vec_t vecs[$];

  button_conditioner #(
    .NUM_BUTTONS      (NB),
    .DEBOUNCE_CYCLES  (DB),
    .LONG_PRESS_CYCLES(LP)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .button_n_raw    (button_n_raw),
    .button_level    (button_level),
    .press_pulse     (press_pulse),
    .release_pulse   (release_pulse),
    .long_press_pulse(long_press_pulse),
    .o_dbg_state     (dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    button_n_raw = 2'b11;
    step();
    reset = 1'b0;
  endtask

  task automatic add_vec(input logic [1:0] raw, input logic rst,
                         input logic [1:0] lvl, input logic [1:0] pr,
                         input logic [1:0] rl, input logic [1:0] lg,
                         input int n);
    vec_t v;
    v.raw = raw; v.rst = rst; v.lvl = lvl; v.pr = pr; v.rl = rl; v.lg = lg;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  // Scoreboard
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [1:0] lvl, input logic [1:0] pr,
                            input logic [1:0] rl, input logic [1:0] lg);
    check({tag, "_level"},   8'(button_level),     8'(lvl));
    check({tag, "_press"},   8'(press_pulse),      8'(pr));
    check({tag, "_release"}, 8'(release_pulse),    8'(rl));
    check({tag, "_long"},    8'(long_press_pulse), 8'(lg));
  endtask

  initial begin
    // Reset state
    reset        = 1'b1;
    button_n_raw = 2'b11;
    step();
    step();
    check_outs("reset", 2'b00, 2'b00, 2'b00, 2'b00);
    check("reset_dbg_state", 8'(dbg_state), 8'h00);
    reset = 1'b0;

    // Vector table: {raw, reset, level, press, release, long, repeat count}.
    // A raw edge applied on vector k shows on the output at vector k+5.
    add_vec(2'b10, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 5);   // clean press ch0
    add_vec(2'b10, 1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 1);
    add_vec(2'b10, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 2);
    add_vec(2'b11, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 5);   // release ch0
    add_vec(2'b11, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 1);
    add_vec(2'b11, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2);
    add_vec(2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 5);   // simultaneous press
    add_vec(2'b00, 1'b0, 2'b11, 2'b11, 2'b00, 2'b00, 1);
    add_vec(2'b00, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 2);
    add_vec(2'b11, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 5);   // simultaneous release
    add_vec(2'b11, 1'b0, 2'b00, 2'b00, 2'b11, 2'b00, 1);
    add_vec(2'b11, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2);
    add_vec(2'b10, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 4);   // reset during press pending
    add_vec(2'b10, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1);
    add_vec(2'b10, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 5);
    add_vec(2'b10, 1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 1);
    add_vec(2'b11, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 5);
    add_vec(2'b11, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 1);

    foreach (vecs[i]) begin
      button_n_raw = vecs[i].raw;
      reset        = vecs[i].rst;
      step();
      check_outs($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].pr, vecs[i].rl, vecs[i].lg);
    end
    reset = 1'b0;

    // Bounce rejection on ch1: 3 low / 2 high, five times.
    do_reset();
    for (int r = 0; r < 5; r++) begin
      button_n_raw = 2'b01;
      for (int c = 0; c < 3; c++) begin
        step();
        check_outs($sformatf("bounce_r%0d_lo%0d", r, c), 2'b00, 2'b00, 2'b00, 2'b00);
      end
      button_n_raw = 2'b11;
      for (int c = 0; c < 2; c++) begin
        step();
        check_outs($sformatf("bounce_r%0d_hi%0d", r, c), 2'b00, 2'b00, 2'b00, 2'b00);
      end
    end
    button_n_raw = 2'b01;
    for (int c = 1; c <= 6; c++) begin
      step();
      check_outs($sformatf("bounce_hold%0d", c), (c == 6) ? 2'b10 : 2'b00,
                 (c == 6) ? 2'b10 : 2'b00, 2'b00, 2'b00);
    end

    // Long press on ch0, then release bounce, then release.
    do_reset();
    button_n_raw = 2'b10;
    for (int c = 1; c <= 6; c++) begin
      step();
      check_outs($sformatf("lp_press%0d", c), (c == 6) ? 2'b01 : 2'b00,
                 (c == 6) ? 2'b01 : 2'b00, 2'b00, 2'b00);
    end
    check("lp_dbg_pressed", 8'(dbg_state[1:0]), 8'h02);
    for (int c = 1; c <= LP; c++) begin
      step();
      check_outs($sformatf("lp_hold%0d", c), 2'b01, 2'b00, 2'b00,
                 (c == LP) ? 2'b01 : 2'b00);
    end
    for (int c = 1; c <= 40; c++) begin
      step();
      check_outs($sformatf("lp_after%0d", c), 2'b01, 2'b00, 2'b00, 2'b00);
    end
    button_n_raw = 2'b11;
    for (int c = 1; c <= 3; c++) begin
      step();
      check_outs($sformatf("rb_hi%0d", c), 2'b01, 2'b00, 2'b00, 2'b00);
    end
    button_n_raw = 2'b10;
    for (int c = 1; c <= 12; c++) begin
      step();
      check_outs($sformatf("rb_lo%0d", c), 2'b01, 2'b00, 2'b00, 2'b00);
    end
    check("rb_dbg_pressed", 8'(dbg_state[1:0]), 8'h02);
    button_n_raw = 2'b11;
    for (int c = 1; c <= 6; c++) begin
      step();
      check_outs($sformatf("lp_release%0d", c), (c == 6) ? 2'b00 : 2'b01, 2'b00,
                 (c == 6) ? 2'b01 : 2'b00, 2'b00);
    end

    // Reset while PRESSED with the key still held: re-debounced afterwards.
    do_reset();
    button_n_raw = 2'b10;
    for (int c = 1; c <= 6; c++) begin
      step();
      check_outs($sformatf("rm_press%0d", c), (c == 6) ? 2'b01 : 2'b00,
                 (c == 6) ? 2'b01 : 2'b00, 2'b00, 2'b00);
    end
    step();
    step();
    reset = 1'b1;
    step();
    check_outs("rm_in_reset", 2'b00, 2'b00, 2'b00, 2'b00);
    check("rm_dbg_reset", 8'(dbg_state), 8'h00);
    reset = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      step();
      check_outs($sformatf("rm_repress%0d", c), (c == 6) ? 2'b01 : 2'b00,
                 (c == 6) ? 2'b01 : 2'b00, 2'b00, 2'b00);
    end

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
